// File: rtl/serial_mag_comp.sv
// Bit-serial magnitude comparator: consumes (a,b) bit pairs MSB first and
// reports a>b / a==b / a<b with a one-cycle done pulse after WIDTH bits.
module serial_mag_comp #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic bit_valid,
  input  logic a_bit,
  input  logic b_bit,
  output logic busy,
  output logic done,
  output logic a_gt_b,
  output logic a_eq_b,
  output logic a_lt_b
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          gt_q, gt_d;
  logic          eq_q, eq_d;
  logic          lt_q, lt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SHIFT;
          cnt_d   = '0;
          gt_d    = 1'b0;
          eq_d    = 1'b1;
          lt_d    = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (bit_valid) begin
          // First differing bit decides; later bits cannot override it.
          if (eq_q && (a_bit != b_bit)) begin
            gt_d = a_bit;
            lt_d = b_bit;
            eq_d = 1'b0;
          end
          if (cnt_q == LAST) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Status outputs are registered, so they are derived from the next state.
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b1;
      lt_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign a_gt_b = gt_q;
  assign a_eq_b = eq_q;
  assign a_lt_b = lt_q;

endmodule
